// File: rtl/dmr_recovery_ctrl.sv
// ============================================================================
// Module   : dmr_recovery_ctrl
// Purpose  : Dual-modular-redundancy recovery sequencer (lockstep, drain, resync, fault).
//            Optional DRAIN/RESYNC timeout enabled by macro DMR_RECOVERY_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmr_recovery_ctrl #(
   parameter int NHARTS         = 2,
   parameter int MAX_RETRIES    = 3,
   parameter int CLEAN_WINDOW   = 256,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              enable_i,
   input  logic              cmp_error_i,
   input  logic              bus_idle_i,
   input  logic              sync_done_i,
   output logic [NHARTS-1:0] halt_o,
   output logic              resync_req_o,
   output logic              fault_o,
   output logic [7:0]        err_count_o,
   output logic [2:0]        state_o
);

   localparam int c_retry_w = $clog2(MAX_RETRIES + 1);
   localparam int c_clean_w = $clog2(CLEAN_WINDOW);
   localparam logic [c_retry_w-1:0] c_retry_max  = c_retry_w'(MAX_RETRIES);
   localparam logic [c_clean_w-1:0] c_clean_last = c_clean_w'(CLEAN_WINDOW - 1);

   if (NHARTS != 2 || MAX_RETRIES < 1 || CLEAN_WINDOW < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("dmr_recovery_ctrl: unsupported parameter set");
   end

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOCKSTEP = 3'd1,
      ST_DRAIN    = 3'd2,
      ST_RESYNC   = 3'd3,
      ST_FAULT    = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [c_retry_w-1:0]  r_retry_cnt;
   logic [c_clean_w-1:0]  r_clean_cnt;
   logic [NHARTS-1:0]     r_halt;
   logic                  r_resync_req;
   logic                  r_fault;
   logic [7:0]            r_err_count;
   logic                  w_retry_clr;
   logic                  w_retry_inc;
   logic                  w_err_inc;
   logic                  w_clean_hit;
   logic                  w_tmo_hit;

   assign w_clean_hit = (r_state == ST_LOCKSTEP) && (r_clean_cnt == c_clean_last);

`ifdef DMR_RECOVERY_TIMEOUT_EN
   localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
   logic [c_tmo_w-1:0] r_tmo_cnt;

   assign w_tmo_hit = ((r_state == ST_DRAIN) || (r_state == ST_RESYNC)) && (r_tmo_cnt == c_tmo_last);

   // Restarts on every state change so DRAIN and RESYNC each get a full budget.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tmo_cnt <= '0;
      end else if (w_state_next != r_state) begin
         r_tmo_cnt <= '0;
      end else if ((r_state == ST_DRAIN) || (r_state == ST_RESYNC)) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
         r_tmo_cnt <= '0;
      end
   end
`else
   assign w_tmo_hit = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      w_retry_clr  = 1'b0;
      w_retry_inc  = 1'b0;
      w_err_inc    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable_i) begin
               w_state_next = ST_LOCKSTEP;
               w_retry_clr  = 1'b1;
            end
         end
         ST_LOCKSTEP: begin
            // An error in the same cycle as the window closing wins over the clear.
            if (cmp_error_i) begin
               w_state_next = ST_DRAIN;
               w_err_inc    = 1'b1;
            end else if (w_clean_hit) begin
               w_retry_clr  = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (w_tmo_hit) begin
               w_state_next = ST_FAULT;
            end else if (bus_idle_i) begin
               w_state_next = (r_retry_cnt < c_retry_max) ? ST_RESYNC : ST_FAULT;
            end
         end
         ST_RESYNC: begin
            if (w_tmo_hit) begin
               w_state_next = ST_FAULT;
            end else if (sync_done_i) begin
               w_state_next = ST_LOCKSTEP;
               w_retry_inc  = 1'b1;
            end
         end
         ST_FAULT: w_state_next = ST_FAULT;
         default:  w_state_next = ST_IDLE;
      endcase
      if (!enable_i) begin
         w_state_next = ST_IDLE;
         w_retry_clr  = 1'b0;
         w_retry_inc  = 1'b0;
         w_err_inc    = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= ST_IDLE;
         r_retry_cnt  <= '0;
         r_clean_cnt  <= '0;
         r_halt       <= '0;
         r_resync_req <= 1'b0;
         r_fault      <= 1'b0;
         r_err_count  <= '0;
      end else begin
         r_state      <= w_state_next;
         // Outputs follow the next state so they change on the same edge as state_o.
         r_halt       <= {NHARTS{(w_state_next == ST_DRAIN) || (w_state_next == ST_RESYNC) ||
                                 (w_state_next == ST_FAULT)}};
         r_resync_req <= (w_state_next == ST_RESYNC);
         r_fault      <= (w_state_next == ST_FAULT);
         if (w_err_inc && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
         end
         if (w_retry_clr) begin
            r_retry_cnt <= '0;
         end else if (w_retry_inc && (r_retry_cnt != c_retry_max)) begin
            r_retry_cnt <= r_retry_cnt + 1'b1;
         end
         if ((r_state == ST_LOCKSTEP) && (w_state_next == ST_LOCKSTEP) && !w_clean_hit) begin
            r_clean_cnt <= r_clean_cnt + 1'b1;
         end else begin
            r_clean_cnt <= '0;
         end
      end
   end

   assign halt_o       = r_halt;
   assign resync_req_o = r_resync_req;
   assign fault_o      = r_fault;
   assign err_count_o  = r_err_count;
   assign state_o      = r_state;

endmodule

`default_nettype wire
